// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register offsets, CTRL field positions and mode codes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

endpackage

// File: rtl/byte_merge.sv
// Merges a 32-bit write into an existing word under per-byte enables;
// byte i occupies bits [8i+7:8i].
module byte_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_byteen,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_byteen[i]) o_merged[8*i +: 8] = i_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/timer_responder.sv
// Countdown timer bus responder: CTRL/PRESET/COUNT registers, a 4-state
// load/count FSM and a one-shot level or periodic pulse interrupt.
module timer_responder
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h0000_7F00,
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  state_t           r_state;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_count;
  logic             r_irq_flag;

  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_periodic;
  logic [31:0] w_ctrl_merged;
  logic [31:0] w_preset_merged;
  logic        w_unused;

  assign w_wr        = sel & (|byteen);
  assign w_wr_ctrl   = w_wr && (addr[3:2] == CTRL_OFF);
  assign w_wr_preset = w_wr && (addr[3:2] == PRESET_OFF);
  assign w_periodic  = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_PERIODIC);

  byte_merge u_ctrl_merge (
    .i_old    ({28'b0, r_ctrl}),
    .i_wdata  (wdata),
    .i_byteen (byteen),
    .o_merged (w_ctrl_merged)
  );

  byte_merge u_preset_merge (
    .i_old    (32'(r_preset)),
    .i_wdata  (wdata),
    .i_byteen (byteen),
    .o_merged (w_preset_merged)
  );

  assign w_unused = &{1'b0, addr[1:0], w_ctrl_merged[31:4]};

  // Statement order encodes priority: a CTRL write clears irq_flag before the
  // FSM may set it, and the bus CTRL value is assigned last so it wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl)   r_irq_flag <= 1'b0;
      if (w_wr_preset) r_preset   <= WIDTH'(w_preset_merged);

      case (r_state)
        IDLE: begin
          if (r_ctrl[CTRL_EN]) r_state <= LOAD;
        end
        LOAD: begin
          r_count <= r_preset;
          r_state <= CNT;
          if (w_periodic) r_irq_flag <= 1'b0;
        end
        CNT: begin
          if (!r_ctrl[CTRL_EN]) begin
            r_state <= IDLE;
          end else if (r_count > WIDTH'(1)) begin
            r_count <= r_count - WIDTH'(1);
          end else begin
            r_count    <= '0;
            r_irq_flag <= 1'b1;
            r_state    <= INT;
          end
        end
        INT: begin
          // Periodic flag drops on the way into LOAD so the pulse is one cycle.
          if (w_periodic) begin
            r_state    <= LOAD;
            r_irq_flag <= 1'b0;
          end else begin
            r_ctrl[CTRL_EN] <= 1'b0;
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_wr_ctrl) r_ctrl <= w_ctrl_merged[3:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      CTRL_OFF:   rdata = {28'b0, r_ctrl};
      PRESET_OFF: rdata = 32'(r_preset);
      COUNT_OFF:  rdata = 32'(r_count);
      default:    rdata = '0;
    endcase
  end

  assign hit = (addr[31:4] == BASE[31:4]);
  assign irq = r_ctrl[CTRL_IM] & r_irq_flag;

endmodule

// File: tb/tb_timer_responder.sv
// Directed-vector bench for timer_responder: reset, one-shot, periodic,
// byte enables, mid-count disable, reset mid-count and same-edge priorities.
module tb_timer_responder;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSV  = 32'h0000_7F0C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  timer_responder #(.BASE(32'h0000_7F00), .WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The write lands at the next rising edge; returns 1 ns after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sel = 1'b1; addr = a; wdata = d; byteen = be;
    tick();
    sel = 1'b0; byteen = '0; wdata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    reset = 1'b0; sel = 1'b0; byteen = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      a = A_CTRL + 32'(i * 4);
      addr = a; #1;
      n_vec++;
      if (rdata !== 32'h0) begin
        n_err++; $display("FAIL reset_rdata off%0d: got %h want %h", i, rdata, 32'h0);
      end
    end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    addr = 32'h0000_7F08; #1;
    n_vec++;
    if (hit !== 1'b1) begin n_err++; $display("FAIL hit_in: got %b want 1", hit); end
    addr = 32'h0000_7F18; #1;
    n_vec++;
    if (hit !== 1'b0) begin n_err++; $display("FAIL hit_out: got %b want 0", hit); end
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_cnt [6] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    logic        exp_irq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus_write(A_PRE, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    addr = A_CNT;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (rdata !== exp_cnt[k]) begin
        n_err++; $display("FAIL oneshot_count edge%0d: got %h want %h", k + 1, rdata, exp_cnt[k]);
      end
      n_vec++;
      if (irq !== exp_irq[k]) begin
        n_err++; $display("FAIL oneshot_irq edge%0d: got %b want %b", k + 1, irq, exp_irq[k]);
      end
    end
    addr = A_CTRL; #1;
    n_vec++;
    if (rdata !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl_en_clr: got %h want %h", rdata, 32'h8); end
    repeat (3) tick();
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL oneshot_irq_held: got %b want 1", irq); end
    bus_write(A_CTRL, 32'h0, 4'hF);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_periodic();
    logic exp;
    bus_write(A_PRE, 32'd2, 4'hF);
    bus_write(A_CTRL, 32'hB, 4'hF);
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp = (k == 4) || (k == 8) || (k == 12);
      n_vec++;
      if (irq !== exp) begin
        n_err++; $display("FAIL periodic_irq edge%0d: got %b want %b", k, irq, exp);
      end
    end
    bus_write(A_CTRL, 32'h0, 4'hF);
    repeat (2) tick();
  endtask

  task automatic test_byteen();
    bus_write(A_PRE, 32'h0, 4'hF);
    bus_write(A_PRE, 32'hAABB_CCDD, 4'b0011);
    addr = A_PRE; #1;
    n_vec++;
    if (rdata !== 32'h0000_CCDD) begin n_err++; $display("FAIL byteen_preset: got %h want %h", rdata, 32'h0000_CCDD); end
    bus_write(A_CNT, 32'hFFFF_FFFF, 4'hF);
    addr = A_CNT; #1;
    n_vec++;
    if (rdata !== 32'd2) begin n_err++; $display("FAIL count_readonly: got %h want %h", rdata, 32'd2); end
    bus_write(A_RSV, 32'h1234_5678, 4'hF);
    addr = A_RSV; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reserved_read: got %h want %h", rdata, 32'h0); end
    bus_write(A_CTRL, 32'h0000_0F00, 4'b0010);
    addr = A_CTRL; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL ctrl_byte1_ignored: got %h want %h", rdata, 32'h0); end
    bus_write(A_CTRL, 32'hFFFF_FFF0, 4'hF);
    addr = A_CTRL; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL ctrl_upper_ignored: got %h want %h", rdata, 32'h0); end
  endtask

  task automatic test_mid_disable();
    bus_write(A_PRE, 32'd10, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    repeat (4) tick();
    bus_write(A_CTRL, 32'h0, 4'hF);
    addr = A_CNT;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (rdata !== 32'd7) begin n_err++; $display("FAIL freeze_count step%0d: got %h want %h", k, rdata, 32'd7); end
      n_vec++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL freeze_irq step%0d: got %b want 0", k, irq); end
      tick();
    end
    bus_write(A_CTRL, 32'h9, 4'hF);
    addr = A_CNT;
    tick();
    n_vec++;
    if (rdata !== 32'd7) begin n_err++; $display("FAIL reenable_load_cycle: got %h want %h", rdata, 32'd7); end
    tick();
    n_vec++;
    if (rdata !== 32'd10) begin n_err++; $display("FAIL reenable_reload: got %h want %h", rdata, 32'd10); end
    bus_write(A_CTRL, 32'h0, 4'hF);
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    bus_write(A_PRE, 32'd10, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    repeat (4) tick();
    reset = 1'b0;
    tick();
    addr = A_CNT; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_count: got %h want %h", rdata, 32'h0); end
    addr = A_CTRL; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_ctrl: got %h want %h", rdata, 32'h0); end
    addr = A_PRE; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_preset: got %h want %h", rdata, 32'h0); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL rstmid_irq: got %b want 0", irq); end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_vec++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet cycle%0d: got %b want 0", k, irq); end
    end
  endtask

  task automatic test_back_to_back();
    bus_write(A_CTRL, 32'h9, 4'hF);
    repeat (2) tick();
    bus_write(A_CTRL, 32'h9, 4'hF);
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL set_beats_ctrl_clear: got %b want 1", irq); end
    bus_write(A_CTRL, 32'h9, 4'hF);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL ctrl_write_clears_flag: got %b want 0", irq); end
    addr = A_CTRL; #1;
    n_vec++;
    if (rdata !== 32'h9) begin n_err++; $display("FAIL bus_beats_en_clear: got %h want %h", rdata, 32'h9); end
    for (int k = 5; k <= 7; k++) begin
      tick();
      n_vec++;
      if (irq !== (k == 7)) begin
        n_err++; $display("FAIL preset0_rerun edge%0d: got %b want %b", k, irq, (k == 7));
      end
    end
    bus_write(A_CTRL, 32'h0, 4'hF);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL final_clear: got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_byteen();
    test_mid_disable();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_responder.md
Name: timer_responder

Overview:
- Memory-mapped countdown timer that acts as a responder on the CPU data bus (m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata).
- The pipeline's memory stage drives it through the system bridge, which decodes the address and asserts sel.
- Provides CTRL, PRESET and COUNT registers and a level/pulse interrupt request for the CP0 interrupt inputs.

Parameters:
- BASE, 32'h0000_7F00, base byte address of the register window; used only to build the hit output.
- WIDTH, 32, width of the PRESET and COUNT registers.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (reset==0 clears the block at the rising edge)
- sel  input  1  bridge chip-select for this device
- addr  input  32  byte address from m_data_addr
- byteen  input  4  byte write enables from m_data_byteen; all-zero means read or no access
- wdata  input  32  write data from m_data_wdata
- rdata  output  32  read data, muxed by the bridge into m_data_rdata
- hit  output  1  addr[31:4]==BASE[31:4]; combinational, independent of sel
- irq  output  1  interrupt request (CTRL.IM & irq_flag)

Behaviour:
- Register map, selected by addr[3:2]:
  - 0: CTRL. Bit [0] EN, bits [2:1] MODE, bit [3] IM. Bits [31:4] read as 0; writes to them are ignored.
  - 1: PRESET, read/write.
  - 2: COUNT, read-only; writes are ignored.
  - 3: reserved. Reads return 0; writes are ignored.
- Writes:
  - A write occurs when sel & |byteen at the rising edge.
  - Bytes are merged per byteen, byte i = bits [8i+7:8i].
  - For CTRL only byte 0 is significant.
- Reads:
  - rdata is combinational from addr[3:2] and current register state, with zero latency.
  - rdata is independent of sel; the bridge qualifies it.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so irq=0 and rdata reads 0 for all offsets.
- FSM states: IDLE, LOAD, CNT, INT (2-bit encoding).
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT<=PRESET; -> CNT. If MODE=1, irq_flag<=0.
  - CNT:
    - EN=0 -> IDLE, COUNT held.
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else COUNT<=0, irq_flag<=1, -> INT.
  - INT, MODE=0 (one-shot): EN<=0; -> IDLE. irq_flag stays 1 until any CTRL write.
  - INT, MODE=1 (periodic): -> LOAD. irq_flag is cleared in LOAD, so irq is a one-cycle pulse.
  - MODE=2 and MODE=3 behave as MODE=0.
- Timing:
  - The write of EN=1 lands at edge 0.
  - irq_flag rises at edge N = max(PRESET,1)+2.
  - In periodic mode, pulses repeat every N cycles while EN=1.
- Simultaneous events:
  - A bus CTRL write in the same cycle as the INT-state EN clear: the bus value wins.
  - Any CTRL write clears irq_flag, except when the FSM sets it at the same edge; then set wins.
  - PRESET written during CNT takes effect at the next LOAD only.
- EN cleared by the bus mid-count: the FSM goes to IDLE next edge and COUNT freezes. Re-enabling reloads from PRESET; there is no resume.
- Arithmetic: COUNT decrements modulo 2^WIDTH. It is never decremented below 0 (guarded by the COUNT>1 test). PRESET=0 behaves as PRESET=1.
- Reset asserted mid-operation: everything returns to reset values at that edge; no irq glitch on the following cycle.

Decomposition:
- Shared package timer_pkg:
  - State encodings IDLE/LOAD/CNT/INT.
  - Register offsets CTRL_OFF=2'd0, PRESET_OFF=2'd1, COUNT_OFF=2'd2.
  - CTRL bit indices EN=0, MODE=2:1, IM=3.
  - Mode constants MODE_ONESHOT=2'd0, MODE_PERIODIC=2'd1.
- One sub-module: byte_merge (old word, wdata, byteen -> merged word), also reusable by the bridge and DM model.

Test Plan:
- Reset then read: with reset=0 held two cycles, then released, read offsets 0/1/2/3 -> rdata=0 for each; irq=0; hit=1 at addr 32'h7F08, hit=0 at 32'h7F18.
- One-shot: write PRESET=3, then CTRL=32'h9 at edge 0 -> COUNT reads 3,2,1,0 on successive cycles; irq=1 from edge 5; CTRL reads 32'h8 (EN cleared); irq stays 1 until CTRL is rewritten with 32'h0, then 0 next cycle.
- Periodic: PRESET=2, CTRL=32'hB -> irq one-cycle pulses at edges 4, 8, 12; each pulse exactly one cycle wide.
- Byte enables: write 32'hAABBCCDD to PRESET with byteen=4'b0011 over PRESET=0 -> reads 32'h0000CCDD; write to COUNT -> value unchanged.
- Mid-count disable: PRESET=10, enable, write CTRL=0 after 4 cycles -> COUNT freezes at its current value, state IDLE, no irq; re-enable -> COUNT reloads 10.
- Reset mid-count: assert reset=0 while in CNT with IM=1 -> next cycle COUNT=0, CTRL=0, irq=0, and no irq for 20 further cycles.
